// File: rtl/lock_report_if.sv
// Request/status and UART transmit signals of the lock reporter, grouped as one bundle.
interface lock_report_if;
  logic        start;
  logic [1:0]  state;
  logic [31:0] value;
  logic        busy;
  logic        done;
  logic [7:0]  txdata;
  logic        txclk;
  logic        txready;

  modport master (
    output start, state, value, txready,
    input  busy, done, txdata, txclk
  );

  modport slave (
    input  start, state, value, txready,
    output busy, done, txdata, txclk
  );
endinterface

// File: rtl/lock_report_tx.sv
// Sends one ASCII line "<state letter>:<hex value><EOL>" per start request
// over a txready/txclk byte handshake.
module lock_report_tx #(
  parameter bit SUPPRESS_ZEROS = 1'b1,
  parameter bit EOL_CRLF       = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  lock_report_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} fsm_t;

  localparam logic [3:0] EOL_LEN = EOL_CRLF ? 4'd2 : 4'd1;

  fsm_t        fsm;
  logic [1:0]  cap_state;
  logic [31:0] cap_value;
  logic [3:0]  cap_ndig;
  logic [3:0]  idx;
  logic        busy;
  logic        done;
  logic        txclk;
  logic [7:0]  txdata;
  logic [7:0]  cur_byte;
  logic [2:0]  digit_sel;
  logic [3:0]  last_idx;

  function automatic logic [7:0] state_letter(input logic [1:0] s);
    case (s)
      2'd0:    return 8'h49;
      2'd1:    return 8'h53;
      2'd2:    return 8'h4F;
      default: return 8'h41;
    endcase
  endfunction

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Number of significant hex digits: 8 minus the leading-zero nibble count, never below 1.
  function automatic logic [3:0] digit_count(input logic [31:0] v);
    logic [3:0] cnt;
    cnt = 4'd1;
    for (int i = 1; i < 8; i++) begin
      if (v[4*i +: 4] != 4'h0) cnt = 4'(i + 1);
    end
    return cnt;
  endfunction

  // Frame layout: idx 0 letter, 1 colon, 2..ndig+1 digits (MS first), then terminator.
  always_comb begin
    cur_byte  = 8'h0A;
    digit_sel = 3'(cap_ndig + 4'd1 - idx);
    if (idx == 4'd0) begin
      cur_byte = state_letter(cap_state);
    end else if (idx == 4'd1) begin
      cur_byte = 8'h3A;
    end else if (idx < 4'd2 + cap_ndig) begin
      cur_byte = hex_ascii(cap_value[{digit_sel, 2'b00} +: 4]);
    end else if (EOL_CRLF && (idx == 4'd2 + cap_ndig)) begin
      cur_byte = 8'h0D;
    end
  end

  assign last_idx = 4'd1 + cap_ndig + EOL_LEN;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm       <= IDLE;
      cap_state <= 2'd0;
      cap_value <= 32'h0;
      cap_ndig  <= 4'd0;
      idx       <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      txclk     <= 1'b0;
      txdata    <= 8'h00;
    end else begin
      done  <= 1'b0;
      txclk <= 1'b0;
      case (fsm)
        IDLE: begin
          if (bus.start) begin
            cap_state <= bus.state;
            cap_value <= bus.value;
            cap_ndig  <= SUPPRESS_ZEROS ? digit_count(bus.value) : 4'd8;
            idx       <= 4'd0;
            busy      <= 1'b1;
            fsm       <= SEND;
          end
        end
        SEND: begin
          if (bus.txready) begin
            txclk  <= 1'b1;
            txdata <= cur_byte;
            fsm    <= WAIT;
          end
        end
        WAIT: begin
          // SEND only strobes with txready high, so a low here is the UART taking the byte.
          if (!bus.txready) begin
            if (idx == last_idx) begin
              busy <= 1'b0;
              done <= 1'b1;
              fsm  <= IDLE;
            end else begin
              idx <= idx + 4'd1;
              fsm <= SEND;
            end
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.txclk  = txclk;
  assign bus.txdata = txdata;

endmodule

// File: tb/tb_lock_report_tx.sv
// Directed bench for lock_report_tx: default, no-suppression and LF-only instances, each with a UART model.
module tb_lock_report_tx;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lock_report_if b0 ();
  lock_report_if b1 ();
  lock_report_if b2 ();

  lock_report_tx dut0 (.clk(clk), .reset(reset), .bus(b0));
  lock_report_tx #(.SUPPRESS_ZEROS(1'b0)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  lock_report_tx #(.EOL_CRLF(1'b0)) dut2 (.clk(clk), .reset(reset), .bus(b2));

  logic        st_start [3];
  logic [1:0]  st_state [3];
  logic [31:0] st_value [3];
  logic        rdy [3] = '{1'b1, 1'b1, 1'b1};
  logic        force_low [3] = '{1'b0, 1'b0, 1'b0};
  int          hold_pulse [3] = '{-1, -1, -1};
  int          pulses [3];
  int          dones [3];
  int          dly [3];
  int          lowc [3];
  logic [7:0]  rx [3][256];

  int total = 0;
  int bad = 0;

  assign b0.start = st_start[0];
  assign b0.state = st_state[0];
  assign b0.value = st_value[0];
  assign b0.txready = rdy[0] & ~force_low[0];
  assign b1.start = st_start[1];
  assign b1.state = st_state[1];
  assign b1.value = st_value[1];
  assign b1.txready = rdy[1] & ~force_low[1];
  assign b2.start = st_start[2];
  assign b2.state = st_state[2];
  assign b2.value = st_value[2];
  assign b2.txready = rdy[2] & ~force_low[2];

  // UART model: records strobed byte, keeps txready high one more cycle (or longer for a chosen pulse), low two cycles.
  task automatic uart_step(input int k, input logic strobe, input logic [7:0] d, input logic dn);
    if (strobe) begin
      rx[k][pulses[k] % 256] = d;
      pulses[k]++;
      dly[k]  = (pulses[k] == hold_pulse[k]) ? 10 : 1;
      lowc[k] = 2;
    end else if (dly[k] > 0) begin
      dly[k]--;
      if (dly[k] == 0) rdy[k] = 1'b0;
    end else if (lowc[k] > 0) begin
      lowc[k]--;
      if (lowc[k] == 0) rdy[k] = 1'b1;
    end
    if (dn) dones[k]++;
  endtask

  always @(negedge clk) begin
    uart_step(0, b0.txclk, b0.txdata, b0.done);
    uart_step(1, b1.txclk, b1.txdata, b1.done);
    uart_step(2, b2.txclk, b2.txdata, b2.done);
  end

  function automatic logic busy_of(input int k);
    case (k)
      0:       return b0.busy;
      1:       return b1.busy;
      default: return b2.busy;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input int k, input logic [1:0] s, input logic [31:0] v,
                             output int bp, output int bd);
    @(negedge clk);
    st_state[k] = s;
    st_value[k] = v;
    st_start[k] = 1'b1;
    bp = pulses[k];
    bd = dones[k];
    @(negedge clk);
    st_start[k] = 1'b0;
  endtask

  task automatic wait_pulses(input int k, input int target, input string tag);
    int t = 0;
    while (pulses[k] < target && t < 500) begin
      @(negedge clk);
      t++;
    end
    check({tag, " reached"}, 32'(pulses[k] >= target), 32'd1);
  endtask

  task automatic wait_done(input int k, input int bd, input string tag);
    int t = 0;
    while (dones[k] == bd && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check({tag, " done pulses"}, 32'(dones[k] - bd), 32'd1);
    check({tag, " busy after"}, 32'(busy_of(k)), 32'd0);
  endtask

  task automatic check_bytes(input int k, input int bp, input logic [95:0] exp, input int n,
                             input string tag);
    check({tag, " count"}, 32'(pulses[k] - bp), 32'(n));
    for (int i = 0; i < n; i++)
      check($sformatf("%s byte%0d", tag, i), {24'h0, rx[k][(bp + i) % 256]},
            {24'h0, exp[8*(n-1-i) +: 8]});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int bp, bd, bpb, bdb, t;
    for (int i = 0; i < 3; i++) begin
      st_start[i] = 1'b0;
      st_state[i] = 2'd0;
      st_value[i] = 32'h0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    check("rst busy", 32'(b0.busy), 32'd0);
    check("rst done", 32'(b0.done), 32'd0);
    check("rst txclk", 32'(b0.txclk), 32'd0);
    check("rst txdata", 32'(b0.txdata), 32'h00);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // SECURE, 0x1234, defaults
    start_frame(0, 2'd1, 32'h0000_1234, bp, bd);
    check("f1 busy rise", 32'(b0.busy), 32'd1);
    check("f1 no early strobe", 32'(b0.txclk), 32'd0);
    @(negedge clk);
    check("f1 first strobe", 32'(b0.txclk), 32'd1);
    check("f1 first data", 32'(b0.txdata), 32'h53);
    wait_done(0, bd, "f1");
    check_bytes(0, bp, 64'h533A_3132_3334_0D0A, 8, "f1");

    // ALARM, zero value, suppressed and unsuppressed
    start_frame(0, 2'd3, 32'h0, bp, bd);
    wait_done(0, bd, "f2");
    check_bytes(0, bp, 40'h413A_300D_0A, 5, "f2");

    start_frame(1, 2'd3, 32'h0, bp, bd);
    wait_done(1, bd, "f3");
    check_bytes(1, bp, 96'h413A_3030_3030_3030_3030_0D0A, 12, "f3");

    // OPEN, A-F digits, LF only
    start_frame(2, 2'd2, 32'hFEDC_BA98, bp, bd);
    wait_done(2, bd, "f4");
    check_bytes(2, bp, 88'h4F3A_4645_4443_4241_3938_0A, 11, "f4");

    // Stall low before the 3rd byte, hold high after the 4th strobe
    start_frame(0, 2'd0, 32'h00AB_C00F, bp, bd);
    hold_pulse[0] = bp + 4;
    wait_pulses(0, bp + 2, "f5 p2");
    force_low[0] = 1'b1;
    repeat (20) @(negedge clk);
    check("f5 no strobe while low", 32'(pulses[0] - bp), 32'd2);
    check("f5 busy while stalled", 32'(b0.busy), 32'd1);
    force_low[0] = 1'b0;
    wait_pulses(0, bp + 4, "f5 p4");
    repeat (6) @(negedge clk);
    check("f5 no duplicate strobe", 32'(pulses[0] - bp), 32'd4);
    wait_done(0, bd, "f5");
    check_bytes(0, bp, 80'h493A_4142_4330_3046_0D0A, 10, "f5");
    hold_pulse[0] = -1;

    // Mid-frame start ignored, then reset after the 3rd byte
    start_frame(0, 2'd1, 32'h0000_1234, bp, bd);
    wait_pulses(0, bp + 1, "f6 p1");
    @(negedge clk);
    st_state[0] = 2'd3;
    st_value[0] = 32'h0000_FFFF;
    st_start[0] = 1'b1;
    repeat (3) @(negedge clk);
    st_start[0] = 1'b0;
    wait_pulses(0, bp + 3, "f6 p3");
    reset = 1'b1;
    #1;
    check("f6 rst busy", 32'(b0.busy), 32'd0);
    check("f6 rst txclk", 32'(b0.txclk), 32'd0);
    check("f6 rst txdata", 32'(b0.txdata), 32'h00);
    check_bytes(0, bp, 24'h533A31, 3, "f6");
    repeat (4) @(negedge clk);
    check("f6 no done", 32'(dones[0] - bd), 32'd0);
    check("f6 no more bytes", 32'(pulses[0] - bp), 32'd3);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    start_frame(0, 2'd2, 32'h0000_0005, bp, bd);
    wait_done(0, bd, "f7");
    check_bytes(0, bp, 40'h4F3A_350D_0A, 5, "f7");

    // Start in the done cycle gives back-to-back frames
    start_frame(0, 2'd1, 32'h0000_0007, bp, bd);
    t = 0;
    while (b0.done !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("b2b done seen", 32'(b0.done), 32'd1);
    check("b2b busy low in done", 32'(b0.busy), 32'd0);
    bpb = pulses[0];
    bdb = bd + 1;
    st_state[0] = 2'd3;
    st_value[0] = 32'h0000_0002;
    st_start[0] = 1'b1;
    @(negedge clk);
    st_start[0] = 1'b0;
    check("b2b busy no gap", 32'(b0.busy), 32'd1);
    check_bytes(0, bp, 40'h533A_370D_0A, 5, "b2b A");
    wait_done(0, bdb, "b2b B");
    check_bytes(0, bpb, 40'h413A_320D_0A, 5, "b2b B");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
